// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB master bridge: FSM state encodings,
// default bus widths and the wait-counter width helper.
package apb_master_bridge_pkg;

    localparam int unsigned DEF_DATAWIDTH    = 32;
    localparam int unsigned DEF_ADDRESSWIDTH = 8;

    // Encodings match the ones the downstream apb_slave uses
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Counter must hold 0..timeout; a zero timeout still needs one bit
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for pready. expired flags the last
// permitted wait cycle; a timeout of 0 disables expiry entirely.
module apb_wait_timer
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned timeout = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW   = cnt_width(timeout);
    localparam int unsigned LAST = (timeout == 0) ? 0 : timeout - 1;
    localparam logic [CW-1:0] LAST_C = LAST[CW-1:0];

    logic [CW-1:0] count;

    // Wait counter: zeroed outside ACCESS, advances once per ACCESS cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (timeout != 0) && enable && (count == LAST_C);

endmodule

// File: rtl/apb_master_bridge.sv
// Command-to-APB bridge: accepts one read/write command at a time, runs a
// SETUP/ACCESS transfer and returns data plus error on a held response port.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned datawidth    = DEF_DATAWIDTH,
    parameter int unsigned addresswidth = DEF_ADDRESSWIDTH,
    parameter int unsigned timeout      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [addresswidth-1:0] cmd_addr,
    input  logic [datawidth-1:0]    cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [datawidth-1:0]    rsp_rdata,
    output logic                    rsp_err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [addresswidth-1:0] paddr,
    output logic [datawidth-1:0]    pwdata,
    input  logic [datawidth-1:0]    prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    apb_state_e state;
    logic       timer_expired;

    // Register-only ready: a new command needs an idle bus and an empty response slot
    assign cmd_ready = (state == ST_IDLE) && !rsp_valid;

    apb_wait_timer #(
        .timeout (timeout)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ST_ACCESS),
        .enable  (state == ST_ACCESS),
        .expired (timer_expired)
    );

    // Transfer FSM with command latch, APB outputs and response register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // The response slot is empty here: commands only enter when it is
                    if (pready) begin
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= pslverr;
                        rsp_valid <= 1'b1;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (timer_expired) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a scoreboard on the response port.
// DUT a uses timeout=16 against a small memory slave; DUT b uses timeout=4
// against a slave that never asserts pready.
module tb_apb_master_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT a signals
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    // DUT b signals
    logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
    logic [7:0]  b_cmd_addr;
    logic [31:0] b_cmd_wdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic        b_psel, b_penable, b_pwrite;
    logic [7:0]  b_paddr;
    logic [31:0] b_pwdata, b_prdata;
    logic        b_pready, b_pslverr;

    apb_master_bridge #(.datawidth(32), .addresswidth(8), .timeout(16)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_master_bridge #(.datawidth(32), .addresswidth(8), .timeout(4)) u_dut_to (
        .clk(clk), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
        .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .psel(b_psel), .penable(b_penable), .pwrite(b_pwrite), .paddr(b_paddr), .pwdata(b_pwdata),
        .prdata(b_prdata), .pready(b_pready), .pslverr(b_pslverr)
    );

    // Memory slave for DUT a; returns junk whenever pready is low
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
    end
    assign prdata   = pready ? mem[paddr] : 32'hBAD0_BAD0;
    assign b_prdata = 32'hCAFE_F00D;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every response handshake
    exp_t ea, eb;
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp_a_unexpected: got rdata %h err %0d, none expected", rsp_rdata, rsp_err);
            end else begin
                ea = q_a.pop_front();
                chk("rsp_a_rdata", rsp_rdata, ea.rdata);
                chk("rsp_a_err", rsp_err, ea.err);
            end
        end
        if (b_rsp_valid && b_rsp_ready) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp_b_unexpected: got rdata %h err %0d, none expected", b_rsp_rdata, b_rsp_err);
            end else begin
                eb = q_b.pop_front();
                chk("rsp_b_rdata", b_rsp_rdata, eb.rdata);
                chk("rsp_b_err", b_rsp_err, eb.err);
            end
        end
    end

    // Present a command on DUT a; returns 1ns after the accepting edge
    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
        bit ok;
        ok = 0;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        chk("accept_in_time", 32'(ok), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        bit seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        chk("rsp_in_time", 32'(seen), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1; pready = 1; pslverr = 0;
        b_cmd_valid = 0; b_cmd_write = 0; b_cmd_addr = '0; b_cmd_wdata = '0;
        b_rsp_ready = 1; b_pready = 0; b_pslverr = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1 rst = 1'b0;

        // Single write with zero wait states
        q_a.push_back({32'h0, 1'b0});
        issue(1'b1, 8'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_setup_psel", psel, 1);
        chk("wr_setup_penable", penable, 0);
        chk("wr_pwrite", pwrite, 1);
        chk("wr_paddr", paddr, 32'h10);
        chk("wr_pwdata", pwdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_access_psel", psel, 1);
        chk("wr_access_penable", penable, 1);
        chk("wr_access_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("wr_rsp_valid_t3", rsp_valid, 1);
        chk("wr_done_psel", psel, 0);
        chk("wr_done_penable", penable, 0);
        chk("wr_hold_paddr", paddr, 32'h10);
        chk("wr_busy_cmd_ready", cmd_ready, 0);

        // Read back, then a second write for the wait-state test
        q_a.push_back({32'hDEAD_BEEF, 1'b0});
        issue(1'b0, 8'h10, 32'h0);
        wait_rsp();
        q_a.push_back({32'h0, 1'b0});
        issue(1'b1, 8'h20, 32'h1234_5678);
        wait_rsp();

        // Three wait states: penable held four cycles, data taken on the ready cycle
        pready = 1'b0;
        q_a.push_back({32'h1234_5678, 1'b0});
        issue(1'b0, 8'h20, 32'h0);
        @(negedge clk);
        chk("ws_setup_penable", penable, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ws_penable_held", penable, 1);
            chk("ws_no_rsp", rsp_valid, 0);
            if (k == 2) begin
                @(posedge clk); #1 pready = 1'b1;
            end
        end
        @(negedge clk);
        chk("ws_rsp_valid", rsp_valid, 1);
        chk("ws_penable_off", penable, 0);

        // Slave error with pready high
        pslverr = 1'b1;
        q_a.push_back({32'h1234_5678, 1'b1});
        issue(1'b0, 8'h20, 32'h0);
        wait_rsp();
        @(posedge clk); #1 pslverr = 1'b0;

        // Timeout on DUT b: four ACCESS cycles then a forced error
        q_b.push_back({32'h0, 1'b1});
        b_cmd_write = 1'b0; b_cmd_addr = 8'h30; b_cmd_valid = 1'b1;
        @(negedge clk);
        chk("to_cmd_ready", b_cmd_ready, 1);
        @(posedge clk); #1 b_cmd_valid = 1'b0;
        @(negedge clk);
        chk("to_setup_psel", b_psel, 1);
        chk("to_setup_penable", b_penable, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to_access_penable", b_penable, 1);
            chk("to_no_rsp_yet", b_rsp_valid, 0);
        end
        @(negedge clk);
        chk("to_rsp_valid", b_rsp_valid, 1);
        chk("to_psel_off", b_psel, 0);
        chk("to_penable_off", b_penable, 0);

        // Backpressure: response held, second command waits
        @(posedge clk); #1 rsp_ready = 1'b0;
        q_a.push_back({32'h0, 1'b0});
        issue(1'b1, 8'h40, 32'h55AA_55AA);
        cmd_write = 1'b0; cmd_addr = 8'h40; cmd_wdata = '0; cmd_valid = 1'b1;
        q_a.push_back({32'h55AA_55AA, 1'b0});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_busy_cmd_ready", cmd_ready, 0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, 0);
            chk("bp_rsp_err", rsp_err, 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_taken_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        chk("bp_next_accept", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        wait_rsp();

        // Reset while in ACCESS: outputs drop at once, no response follows
        @(posedge clk); #1 pready = 1'b0;
        issue(1'b0, 8'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_in_access", penable, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_psel", psel, 0);
        chk("rstmid_penable", penable, 0);
        chk("rstmid_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1 rst = 1'b0; pready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid_no_rsp", rsp_valid, 0);
        end
        chk("rstmid_idle", cmd_ready, 1);

        // Drain and verify every expected response arrived
        for (int i = 0; i < 50; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(negedge clk);
        end
        chk("pending_a", q_a.size(), 0);
        chk("pending_b", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
